// File: rtl/mul_rill_seq.sv
// Sequential shift-add multiply-accumulate: product = a*b + c at 2*WIDTH precision,
// one multiplier bit per clock, fixed latency with a start/busy/done handshake.
module mul_rill_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [PW-1:0]      mcand, mcand_nxt;
  logic [PW-1:0]      acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]      product_nxt;
  logic               ovf_nxt;
  logic               busy_nxt;
  logic               done_nxt;

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mplier  <= '0;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      mplier  <= mplier_nxt;
      mcand   <= mcand_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      product <= product_nxt;
      ovf     <= ovf_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  // Next-state, operand load and one shift-add step per RUN cycle
  always_comb begin
    state_nxt   = state;
    mplier_nxt  = mplier;
    mcand_nxt   = mcand;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    product_nxt = product;
    ovf_nxt     = ovf;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          mplier_nxt = a;
          mcand_nxt  = PW'(b);
          acc_nxt    = PW'(c);
          cnt_nxt    = '0;
          state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        mplier_nxt = mplier >> 1;
        mcand_nxt  = mcand << 1;
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_nxt   = S_DONE;
          product_nxt = acc_nxt;
          ovf_nxt     = |acc_nxt[PW-1:WIDTH];
        end
      end
      S_DONE: begin
        if (start) begin
          mplier_nxt = a;
          mcand_nxt  = PW'(b);
          acc_nxt    = PW'(c);
          cnt_nxt    = '0;
          state_nxt  = S_RUN;
        end else begin
          state_nxt  = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt == S_RUN);
    done_nxt = (state_nxt == S_DONE);
  end

endmodule
